mem_arbiter: RTL and testbench

Two-port arbiter that shares the single external word-granular memory interface between the instruction cache and the data cache. It sits between both caches' memory-side ports and the backing memory. It grants the memory to one cache at a time and holds the grant until that cache's transaction (line fill, write-through) has fully drained. It routes each read response back to the cache that issued it.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-granular memory port between the I-cache and the D-cache.
// The grant is held until the owner's transaction drains, and read data goes back to the owner.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_imem_* / o_imem_*             instruction-cache request and response side
//   i_dmem_* / o_dmem_*             data-cache request and response side
//   i_mem_* / o_mem_*               backing memory side (responses arrive in order)
//   o_gnt_i, o_gnt_d                current grant (one-hot or both 0)
//   o_err                           sticky protocol-error flag
module mem_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_imem_ren,
    input  logic        i_imem_wen,
    input  logic [31:0] i_imem_addr,
    input  logic [31:0] i_imem_wdata,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_gnt_i,
    output logic        o_gnt_d,
    output logic        o_err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] C_MAX  = CW'(MAX_OUT);
    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_d;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic          w_ireq;
    logic          w_dreq;
    logic          w_cnt_zero;
    logic          w_rsp;
    logic          w_acc_rd;
    logic          w_inc;
    logic          w_dec;
    logic          w_err_set;

    assign w_ireq     = i_imem_ren | i_imem_wen;
    assign w_dreq     = i_dmem_ren | i_dmem_wen;
    assign w_cnt_zero = (r_cnt == C_ZERO);

    // A response with nothing outstanding is stray: it is dropped and flagged.
    assign w_rsp    = i_mem_valid & ~w_cnt_zero;
    assign w_acc_rd = o_mem_ren & i_mem_ready;
    assign w_inc    = w_acc_rd & (r_cnt != C_MAX);
    assign w_dec    = w_rsp;

    assign w_err_set = (w_acc_rd & (r_cnt == C_MAX))
                     | (i_mem_valid & w_cnt_zero)
                     | (i_imem_ren & i_imem_wen)
                     | (i_dmem_ren & i_dmem_wen);

    // Owner's request and responses pass straight through; everyone else sees zeros.
    always_comb begin : route
        o_mem_addr   = '0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = '0;
        o_imem_ready = 1'b0;
        o_imem_valid = 1'b0;
        o_imem_rdata = '0;
        o_dmem_ready = 1'b0;
        o_dmem_valid = 1'b0;
        o_dmem_rdata = '0;
        unique case (r_state)
            GNT_I: begin
                o_mem_addr   = i_imem_addr;
                o_mem_ren    = i_imem_ren;
                o_mem_wen    = i_imem_wen;
                o_mem_wdata  = i_imem_wdata;
                o_imem_ready = i_mem_ready;
                o_imem_valid = w_rsp;
                o_imem_rdata = w_rsp ? i_mem_rdata : '0;
            end
            GNT_D: begin
                o_mem_addr   = i_dmem_addr;
                o_mem_ren    = i_dmem_ren;
                o_mem_wen    = i_dmem_wen;
                o_mem_wdata  = i_dmem_wdata;
                o_dmem_ready = i_mem_ready;
                o_dmem_valid = w_rsp;
                o_dmem_rdata = w_rsp ? i_mem_rdata : '0;
            end
            default: ;
        endcase
    end

    always_comb begin : next_state
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                // On a tie the side not granted last wins.
                if (w_ireq && w_dreq) begin
                    w_next = r_last_d ? GNT_I : GNT_D;
                end else if (w_dreq) begin
                    w_next = GNT_D;
                end else if (w_ireq) begin
                    w_next = GNT_I;
                end
            end
            GNT_I: begin
                if (!w_ireq && w_cnt_zero) begin
                    w_next = IDLE;
                end
            end
            GNT_D: begin
                if (!w_dreq && w_cnt_zero) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_cnt    <= C_ZERO;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != IDLE && w_next == IDLE) begin
                r_last_d <= (r_state == GNT_D);
            end
            if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + C_ONE;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - C_ONE;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_gnt_i = (r_state == GNT_I);
    assign o_gnt_d = (r_state == GNT_D);
    assign o_err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a behavioural arbiter model checked every cycle,
// plus hand-computed literal expectations for grant timing, drain, backpressure and errors.
module tb_mem_arbiter;

    localparam int MAX_OUT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_imem_ren, i_imem_wen;
    logic [31:0] i_imem_addr, i_imem_wdata;
    logic        o_imem_ready, o_imem_valid;
    logic [31:0] o_imem_rdata;
    logic        i_dmem_ren, i_dmem_wen;
    logic [31:0] i_dmem_addr, i_dmem_wdata;
    logic        o_dmem_ready, o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren, o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        o_gnt_i, o_gnt_d, o_err;

    mem_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_imem_ren(i_imem_ren), .i_imem_wen(i_imem_wen),
        .i_imem_addr(i_imem_addr), .i_imem_wdata(i_imem_wdata),
        .o_imem_ready(o_imem_ready), .o_imem_valid(o_imem_valid),
        .o_imem_rdata(o_imem_rdata),
        .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
        .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata),
        .o_dmem_ready(o_dmem_ready), .o_dmem_valid(o_dmem_valid),
        .o_dmem_rdata(o_dmem_rdata),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .i_mem_valid(i_mem_valid),
        .o_gnt_i(o_gnt_i), .o_gnt_d(o_gnt_d), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int nchk = 0;
    int nerr = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Memory: every accepted read returns 2 cycles later.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t mq[$];
    int   cyc = 0;
    bit   auto_mem = 1'b1;

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (auto_mem) begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = mq[0].data;
                void'(mq.pop_front());
            end else begin
                i_mem_valid = 1'b0;
                i_mem_rdata = '0;
            end
        end
    endtask

    // Behavioural model: owner -1 none, 0 = I, 1 = D.
    int          m_owner = -1;
    int          m_last = 0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_ok = 1'b0;
    int          d_vld_seen = 0;
    int          i_vld_seen = 0;
    int          wr_seen = 0;
    bit          mr[2], mw[2], mq_req[2];
    logic [31:0] ma[2], md[2];
    bit          e_ren, e_wen, e_acc, e_vld;
    logic [31:0] e_addr, e_wd;
    int          own, ncnt;

    always @(negedge i_clk) begin
        mr[0] = i_imem_ren;  mw[0] = i_imem_wen;
        ma[0] = i_imem_addr; md[0] = i_imem_wdata;
        mr[1] = i_dmem_ren;  mw[1] = i_dmem_wen;
        ma[1] = i_dmem_addr; md[1] = i_dmem_wdata;
        mq_req[0] = mr[0] | mw[0];
        mq_req[1] = mr[1] | mw[1];
        own    = (m_owner < 0) ? 0 : m_owner;
        e_ren  = (m_owner >= 0) && mr[own];
        e_wen  = (m_owner >= 0) && mw[own];
        e_addr = (m_owner >= 0) ? ma[own] : 32'h0;
        e_wd   = (m_owner >= 0) ? md[own] : 32'h0;
        e_vld  = (m_owner >= 0) && i_mem_valid && (m_cnt > 0);
        if (m_ok) begin
            chk("mdl_gnt_i", o_gnt_i, m_owner == 0);
            chk("mdl_gnt_d", o_gnt_d, m_owner == 1);
            chk("mdl_mem_ren", o_mem_ren, e_ren);
            chk("mdl_mem_wen", o_mem_wen, e_wen);
            chk("mdl_mem_addr", o_mem_addr, e_addr);
            chk("mdl_mem_wdata", o_mem_wdata, e_wd);
            chk("mdl_i_ready", o_imem_ready, (m_owner == 0) && i_mem_ready);
            chk("mdl_d_ready", o_dmem_ready, (m_owner == 1) && i_mem_ready);
            chk("mdl_i_valid", o_imem_valid, e_vld && m_owner == 0);
            chk("mdl_d_valid", o_dmem_valid, e_vld && m_owner == 1);
            chk("mdl_i_rdata", o_imem_rdata,
                (e_vld && m_owner == 0) ? i_mem_rdata : 32'h0);
            chk("mdl_d_rdata", o_dmem_rdata,
                (e_vld && m_owner == 1) ? i_mem_rdata : 32'h0);
            chk("mdl_err", o_err, m_err);
        end
        if (o_dmem_valid) d_vld_seen++;
        if (o_imem_valid) i_vld_seen++;
        if (o_mem_wen && i_mem_ready && !i_rst) wr_seen++;
        if (auto_mem && o_mem_ren && i_mem_ready && !i_rst)
            mq.push_back('{cyc + 2, o_mem_addr ^ 32'hA5A5_0000});
        if (i_rst) begin
            m_owner = -1;
            m_last  = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            m_ok    = 1'b1;
        end else begin
            e_acc = e_ren && i_mem_ready;
            if (i_mem_valid && m_cnt == 0) m_err = 1'b1;
            if (e_acc && m_cnt == MAX_OUT) m_err = 1'b1;
            if ((mr[0] && mw[0]) || (mr[1] && mw[1])) m_err = 1'b1;
            ncnt = m_cnt + ((e_acc && m_cnt < MAX_OUT) ? 1 : 0)
                         - ((i_mem_valid && m_cnt > 0) ? 1 : 0);
            if (m_owner < 0) begin
                if (mq_req[0] && mq_req[1]) m_owner = 1 - m_last;
                else if (mq_req[1]) m_owner = 1;
                else if (mq_req[0]) m_owner = 0;
            end else if (!mq_req[own] && m_cnt == 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end
            m_cnt = ncnt;
        end
    end

    // Called just after a clock edge; returns at a negedge where no grant is held.
    task automatic wait_idle(string nm);
        int n = 0;
        @(negedge i_clk);
        while ((o_gnt_i || o_gnt_d) && n < 40) begin
            tick();
            @(negedge i_clk);
            n++;
        end
        chk(nm, {30'd0, o_gnt_i, o_gnt_d}, 0);
    endtask

    // Tie in IDLE: D writes once and releases; I then gets the grant after a bubble.
    task automatic tie_round(string nm, logic [31:0] ia);
        tick();
        i_imem_ren   = 1'b1;
        i_imem_addr  = ia;
        i_dmem_wen   = 1'b1;
        i_dmem_addr  = 32'h500;
        i_dmem_wdata = 32'h1111_1111;
        tick();
        @(negedge i_clk);
        chk({nm, "_gnt_d"}, o_gnt_d, 1);
        chk({nm, "_no_gnt_i"}, o_gnt_i, 0);
        tick();
        i_dmem_wen = 1'b0;
        @(negedge i_clk);
        chk({nm, "_hold_d"}, o_gnt_d, 1);
        tick();
        @(negedge i_clk);
        chk({nm, "_bubble"}, {30'd0, o_gnt_i, o_gnt_d}, 0);
        tick();
        @(negedge i_clk);
        chk({nm, "_gnt_i"}, o_gnt_i, 1);
        tick();
        i_imem_ren = 1'b0;
        wait_idle({nm, "_release"});
    endtask

    task automatic do_reset(string nm);
        tick();
        i_rst = 1'b1;
        tick();
        @(negedge i_clk);
        chk({nm, "_err"}, o_err, 0);
        chk({nm, "_gnt"}, {30'd0, o_gnt_i, o_gnt_d}, 0);
        chk({nm, "_mem"}, {29'd0, o_mem_ren, o_mem_wen, |o_mem_addr}, 0);
        chk({nm, "_rdy"}, {30'd0, o_imem_ready, o_dmem_ready}, 0);
        tick();
        i_rst = 1'b0;
    endtask

    int k;
    int n;

    initial begin
        i_rst        = 1'b1;
        i_imem_ren   = 1'b0;
        i_imem_wen   = 1'b0;
        i_imem_addr  = '0;
        i_imem_wdata = '0;
        i_dmem_ren   = 1'b0;
        i_dmem_wen   = 1'b0;
        i_dmem_addr  = '0;
        i_dmem_wdata = '0;
        i_mem_ready  = 1'b1;
        i_mem_valid  = 1'b0;
        i_mem_rdata  = '0;

        do_reset("reset");

        // D fill alone: 4 reads from 0x100.
        d_vld_seen = 0;
        i_vld_seen = 0;
        i_dmem_ren  = 1'b1;
        i_dmem_addr = 32'h100;
        tick();
        @(negedge i_clk);
        chk("fill_gnt_d", o_gnt_d, 1);
        chk("fill_first_addr", o_mem_addr, 32'h100);
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            if (o_dmem_ready) k++;
            tick();
            n++;
            if (k == 4) i_dmem_ren = 1'b0;
            else i_dmem_addr = 32'h100 + 32'(4 * k);
            if (k < 4) @(negedge i_clk);
        end
        chk("fill_accepts", k, 4);
        wait_idle("fill_release");
        chk("fill_d_valids", d_vld_seen, 4);
        chk("fill_i_valids", i_vld_seen, 0);

        // Tie after reset goes to D; a second tie goes to D again.
        do_reset("reset2");
        tie_round("tie1", 32'h400);
        tie_round("tie2", 32'h404);

        // I cannot steal while D drains two outstanding reads.
        d_vld_seen = 0;
        tick();
        i_dmem_ren  = 1'b1;
        i_dmem_addr = 32'h300;
        tick();
        @(negedge i_clk);
        chk("drain_gnt_d", o_gnt_d, 1);
        tick();
        i_dmem_addr = 32'h304;
        i_imem_ren  = 1'b1;
        i_imem_addr = 32'h600;
        tick();
        i_dmem_ren = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            chk("drain_hold_d", o_gnt_d, 1);
            chk("drain_i_ready", o_imem_ready, 0);
            tick();
        end
        @(negedge i_clk);
        chk("drain_d_valids", d_vld_seen, 2);
        chk("drain_bubble", {30'd0, o_gnt_i, o_gnt_d}, 0);
        tick();
        @(negedge i_clk);
        chk("drain_gnt_i", o_gnt_i, 1);
        tick();
        i_imem_ren = 1'b0;
        wait_idle("drain_release");

        // Backpressure on a D write.
        wr_seen = 0;
        tick();
        i_mem_ready  = 1'b0;
        i_dmem_wen   = 1'b1;
        i_dmem_addr  = 32'h200;
        i_dmem_wdata = 32'hDEAD_BEEF;
        for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge i_clk);
            chk("bp_wen", o_mem_wen, 1);
            chk("bp_addr", o_mem_addr, 32'h200);
            chk("bp_wdata", o_mem_wdata, 32'hDEAD_BEEF);
            chk("bp_d_ready", o_dmem_ready, 0);
        end
        tick();
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_ready_cycle", o_dmem_ready, 1);
        tick();
        i_dmem_wen = 1'b0;
        @(negedge i_clk);
        chk("bp_one_write", wr_seen, 1);
        wait_idle("bp_release");

        // Error (a): stray response in IDLE.
        tick();
        @(negedge i_clk);
        chk("err_clean", o_err, 0);
        tick();
        auto_mem    = 1'b0;
        i_mem_valid = 1'b1;
        i_mem_rdata = 32'h0000_1234;
        @(negedge i_clk);
        chk("err_a_i_valid", o_imem_valid, 0);
        chk("err_a_d_valid", o_dmem_valid, 0);
        tick();
        i_mem_valid = 1'b0;
        i_mem_rdata = '0;
        auto_mem    = 1'b1;
        @(negedge i_clk);
        chk("err_a_set", o_err, 1);

        // Error (c): reset clears it.
        do_reset("err_c");

        // Error (b): D asserts ren and wen together.
        tick();
        i_dmem_ren  = 1'b1;
        i_dmem_wen  = 1'b1;
        i_dmem_addr = 32'h700;
        tick();
        tick();
        @(negedge i_clk);
        chk("err_b_set", o_err, 1);
        tick();
        i_dmem_ren = 1'b0;
        i_dmem_wen = 1'b0;
        wait_idle("err_b_release");
        do_reset("err_b_clear");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
